// File: rtl/stage_ma.sv
// Memory-access stage: drives a single-outstanding req/gnt/rvalid data bus for
// byte/half/word loads and stores, and registers the result into MA-WB.
package stage_ma_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] alu_result;
      logic [31:0] dmem_data;
      logic        dmem_rd_en;
      logic        dmem_wr_en;
      logic [1:0]  dmem_size;
      logic        dmem_sign;
      logic [31:0] pc_plus_four;
      logic        reg_wr_en;
      logic [1:0]  reg_wr_sel;
      logic [4:0]  reg_wr_addr;
   } ex_ma_reg_t;

   typedef struct packed {
      logic        valid;
      logic        reg_wr_en;
      logic [1:0]  reg_wr_sel;
      logic [4:0]  reg_wr_addr;
      logic [31:0] alu_result;
      logic [31:0] pc_plus_four;
      logic [31:0] load_data;
   } ma_wb_reg_t;
endpackage

module stage_ma
   import stage_ma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_i,
   input  ex_ma_reg_t  ex_ma_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic        misalign_o,
   output ma_wb_reg_t  ma_wb_reg_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] load_hold_q, load_hold_d;
   ma_wb_reg_t  ma_wb_q, ma_wb_d;

   logic [1:0]  addr_lo;
   logic        is_mem, bad_align, misalign, mem_op;
   logic [31:0] rd_shift, load_ext;

   assign addr_lo = ex_ma_i.alu_result[1:0];

   always_comb begin
      is_mem = ex_ma_i.valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);
      case (ex_ma_i.dmem_size)
         2'b01:   bad_align = addr_lo[0];
         2'b10:   bad_align = |addr_lo;
         2'b11:   bad_align = 1'b1;
         default: bad_align = 1'b0;
      endcase
      misalign = is_mem & bad_align;
      mem_op   = is_mem & ~bad_align;
   end

   always_comb begin
      case (ex_ma_i.dmem_size)
         2'b00: begin
            dmem_be_o    = 4'b0001 << addr_lo;
            dmem_wdata_o = {4{ex_ma_i.dmem_data[7:0]}};
         end
         2'b01: begin
            dmem_be_o    = 4'b0011 << addr_lo;
            dmem_wdata_o = {2{ex_ma_i.dmem_data[15:0]}};
         end
         default: begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = ex_ma_i.dmem_data;
         end
      endcase
   end

   // dmem_sign=1 selects zero extension (LBU/LHU)
   always_comb begin
      rd_shift = dmem_rdata_i >> {addr_lo, 3'b000};
      case (ex_ma_i.dmem_size)
         2'b00:   load_ext = ex_ma_i.dmem_sign ? {24'b0, rd_shift[7:0]}
                                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_ext = ex_ma_i.dmem_sign ? {16'b0, rd_shift[15:0]}
                                               : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = rd_shift;
      endcase
   end

   assign dmem_addr_o = {ex_ma_i.alu_result[31:2], 2'b00};
   assign dmem_we_o   = ex_ma_i.dmem_wr_en;
   assign misalign_o  = misalign & (state_q == ST_IDLE);

   // A store granted in its first cycle completes without stalling, so the FSM
   // stays in IDLE and is ready for the next instruction entering MA.
   always_comb begin
      state_d     = state_q;
      load_hold_d = load_hold_q;
      dmem_req_o  = 1'b0;
      stall_o     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dmem_req_o = mem_op;
            if (mem_op) begin
               if (!dmem_gnt_i) begin
                  state_d = ST_REQ;
                  stall_o = 1'b1;
               end else if (!ex_ma_i.dmem_wr_en) begin
                  state_d = ST_RESP;
                  stall_o = 1'b1;
               end
            end
         end
         ST_REQ: begin
            dmem_req_o = 1'b1;
            stall_o    = 1'b1;
            if (dmem_gnt_i) state_d = ex_ma_i.dmem_wr_en ? ST_DONE : ST_RESP;
         end
         ST_RESP: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) begin
               load_hold_d = load_ext;
               state_d     = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ma_wb_d = ma_wb_q;
      if (stall_o) begin
         ma_wb_d.valid = 1'b0;
      end else begin
         ma_wb_d.valid        = ex_ma_i.valid & ~misalign;
         ma_wb_d.reg_wr_en    = ex_ma_i.reg_wr_en;
         ma_wb_d.reg_wr_sel   = ex_ma_i.reg_wr_sel;
         ma_wb_d.reg_wr_addr  = ex_ma_i.reg_wr_addr;
         ma_wb_d.alu_result   = ex_ma_i.alu_result;
         ma_wb_d.pc_plus_four = ex_ma_i.pc_plus_four;
         ma_wb_d.load_data    = load_hold_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         load_hold_q <= '0;
         ma_wb_q     <= '0;
      end else begin
         state_q     <= state_d;
         load_hold_q <= load_hold_d;
         ma_wb_q     <= ma_wb_d;
      end
   end

   assign ma_wb_reg_o = ma_wb_q;

endmodule

// File: tb/tb_stage_ma.sv
// Bench for stage_ma: acts as upstream pipeline and data-memory bus, and checks
// strobes, store data, stall counts and writebacks against a byte-level memory model.
module tb_stage_ma;
   import stage_ma_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   ex_ma_reg_t  ex_ma_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o, misalign_o;
   ma_wb_reg_t  ma_wb_reg_o;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [0:1023];
   logic [31:0] bus_mem [0:255];

   always #5 clk = ~clk;

   stage_ma u_dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .ex_ma_i       (ex_ma_i),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i),
      .stall_o       (stall_o),
      .misalign_o    (misalign_o),
      .ma_wb_reg_o   (ma_wb_reg_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] w);
      bus_mem[idx] = w;
      for (int i = 0; i < 4; i++) ref_mem[idx*4+i] = w[8*i +: 8];
   endtask

   function automatic ex_ma_reg_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic sgn, input logic [31:0] addr,
                                     input logic [31:0] data);
      ex_ma_reg_t r;
      r              = '0;
      r.valid        = 1'b1;
      r.alu_result   = addr;
      r.dmem_data    = data;
      r.dmem_rd_en   = rd;
      r.dmem_wr_en   = wr;
      r.dmem_size    = sz;
      r.dmem_sign    = sgn;
      r.pc_plus_four = $urandom;
      r.reg_wr_en    = ~wr;
      r.reg_wr_sel   = rd ? 2'd1 : 2'd0;
      r.reg_wr_addr  = 5'($urandom_range(1, 31));
      return r;
   endfunction

   // Present one instruction in MA, play the bus with the given grant and response
   // delays, and check everything up to the instruction's writeback.
   task automatic run_instr(input ex_ma_reg_t ins, input int gdly, input int rdly,
                            output logic [31:0] ld_out, output int stalls);
      int          nb, a, c, reqs, gcyc, exp_st;
      logic        is_mem, mis, mop, is_ld, is_st, granted, g_we, st, done;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_ld, gaddr;
      a      = int'(ins.alu_result[9:0]);
      nb     = 1 << ins.dmem_size;
      is_mem = ins.valid && (ins.dmem_rd_en || ins.dmem_wr_en);
      mis    = is_mem && (ins.dmem_size == 2'd3 || (a % nb) != 0);
      mop    = is_mem && !mis;
      is_st  = mop && ins.dmem_wr_en;
      is_ld  = mop && !ins.dmem_wr_en;
      for (int i = 0; i < 4; i++) begin
         exp_be[i]         = (i >= a % 4) && (i < a % 4 + nb);
         exp_wd[8*i +: 8]  = ins.dmem_data[8*(i % nb) +: 8];
      end
      exp_ld = 32'd0;
      if (is_ld) begin
         for (int i = 0; i < nb && i < 4; i++) exp_ld = exp_ld | (32'(ref_mem[a+i]) << (8*i));
         if (nb < 4 && !ins.dmem_sign && exp_ld[8*nb-1]) exp_ld = exp_ld | (32'hFFFF_FFFF << (8*nb));
      end
      exp_st = is_ld ? gdly + rdly + 1 : (is_st && gdly > 0) ? gdly + 1 : 0;

      ex_ma_i = ins;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      c = 0; reqs = 0; gcyc = 0; granted = 1'b0; g_we = 1'b0; gaddr = '0;
      stalls = 0; done = 1'b0;
      while (!done) begin
         #1;
         dmem_gnt_i    = dmem_req_o && !granted && (c >= gdly);
         dmem_rvalid_i = 1'b0;
         dmem_rdata_i  = $urandom;
         if (granted && !g_we && c == gcyc + rdly) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = bus_mem[gaddr[9:2]];
         end
         #1;
         if (c == 0) chk("misalign_o", 32'(misalign_o), 32'(mis));
         if (dmem_req_o) begin
            reqs++;
            if (mop) begin
               chk("addr", dmem_addr_o, {ins.alu_result[31:2], 2'b00});
               chk("we", 32'(dmem_we_o), 32'(ins.dmem_wr_en));
               chk("be", 32'(dmem_be_o), 32'(exp_be));
               if (is_st) chk("wdata", dmem_wdata_o, exp_wd);
            end
            if (dmem_gnt_i) begin
               granted = 1'b1; gcyc = c; gaddr = dmem_addr_o; g_we = dmem_we_o;
               if (dmem_we_o)
                  for (int i = 0; i < 4; i++)
                     if (dmem_be_o[i]) bus_mem[dmem_addr_o[9:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
            end
         end
         st = stall_o;
         if (st) stalls++;
         @(posedge clk); #1;
         if (st) chk("bubble_valid", 32'(ma_wb_reg_o.valid), 32'd0);
         else done = 1'b1;
         c++;
         if (!done && c > 40) begin
            chk("timeout", 32'd1, 32'd0);
            done = 1'b1;
         end
      end
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;

      chk("stall_cycles", 32'(stalls), 32'(exp_st));
      chk("req_cycles", 32'(reqs), mop ? 32'(gdly + 1) : 32'd0);
      chk("wb_valid", 32'(ma_wb_reg_o.valid), 32'(ins.valid && !mis));
      if (ins.valid && !mis) begin
         chk("wb_rd", 32'(ma_wb_reg_o.reg_wr_addr), 32'(ins.reg_wr_addr));
         chk("wb_pc4", ma_wb_reg_o.pc_plus_four, ins.pc_plus_four);
         chk("wb_alu", ma_wb_reg_o.alu_result, ins.alu_result);
         if (is_ld) chk("wb_load", ma_wb_reg_o.load_data, exp_ld);
      end
      ld_out = ma_wb_reg_o.load_data;
      if (is_st) for (int i = 0; i < nb; i++) ref_mem[a+i] = ins.dmem_data[8*i +: 8];
   endtask

   initial begin
      logic [31:0] ld;
      int          st;
      ex_ma_reg_t  ins;
      rst_i = 1'b1; ex_ma_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      for (int w = 0; w < 256; w++) set_word(w, $urandom);
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      #2;
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
      chk("rst_mawb_zero", 32'(|ma_wb_reg_o), 32'd0);
      @(posedge clk); #1;

      // SW, immediate grant
      run_instr(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF), 0, 1, ld, st);
      chk("sw_mem", bus_mem[32'h100 >> 2], 32'hDEAD_BEEF);
      // LB / LBU of 0x80 byte
      set_word(32'h103 >> 2, 32'h80FF_FF7F);
      run_instr(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0), 0, 1, ld, st);
      chk("lb_const", ld, 32'hFFFF_FF80);
      chk("lb_stalls", 32'(st), 32'd2);
      run_instr(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0), 0, 1, ld, st);
      chk("lbu_const", ld, 32'h0000_0080);
      // SH, grant in third request cycle
      run_instr(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD), 2, 1, ld, st);
      chk("sh_stalls", 32'(st), 32'd3);
      chk("sh_mem_hi", 32'(bus_mem[32'h202 >> 2][31:16]), 32'h0000_ABCD);
      // misaligned LW
      run_instr(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0), 0, 1, ld, st);

      // reset while waiting for rvalid, then a stray rvalid
      ex_ma_i = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      #1 dmem_gnt_i = dmem_req_o;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0;
      #1 chk("resp_stall", 32'(stall_o), 32'd1);
      rst_i = 1'b1; ex_ma_i = '0;
      @(posedge clk); #1;
      rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
      #1;
      chk("rst_resp_stall", 32'(stall_o), 32'd0);
      chk("rst_resp_req", 32'(dmem_req_o), 32'd0);
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
      chk("stray_rvalid_wb", 32'(ma_wb_reg_o.valid), 32'd0);
      @(posedge clk); #1;
      chk("stray_rvalid_wb2", 32'(ma_wb_reg_o.valid), 32'd0);

      // LW, ADD, SB back to back
      run_instr(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0), $urandom_range(0, 3), $urandom_range(1, 3), ld, st);
      run_instr(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0), 0, 1, ld, st);
      chk("add_no_stall", 32'(st), 32'd0);
      run_instr(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h45, 32'h0000_00A5), $urandom_range(0, 3), 1, ld, st);

      // random traffic
      for (int n = 0; n < 200; n++) begin
         logic [31:0] addr;
         int kind;
         kind = $urandom_range(0, 3);
         addr = {22'($urandom), 10'($urandom)};
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         ins = mk(kind == 1, kind >= 2, 2'($urandom), 1'($urandom), addr, $urandom);
         if ($urandom_range(0, 9) == 0) ins.valid = 1'b0;
         run_instr(ins, $urandom_range(0, 3), $urandom_range(1, 3), ld, st);
      end
      ex_ma_i = '0;
      @(posedge clk); #1;
      for (int w = 0; w < 256; w++)
         if (bus_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
            chk("mem_image", bus_mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      chk("mem_word0", bus_mem[0], {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
